// File: rtl/reg_cnt_updn_pkg.sv
// Shared types and helpers for the reg_cnt_updn counter register.
// Holds the command encoding, the priority decoder and the modulo helper
// used by the step arithmetic.
package reg_cnt_pkg;

    // Resolved command for one clock cycle, after priority arbitration.
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LD,
        OP_INC,
        OP_DEC
    } cnt_op_t;

    // Width of the scratch arithmetic used by mod_reduce; counters wider
    // than MOD_W-1 bits are not supported.
    localparam int MOD_W = 32;

    // Priority: clr > ld > (inc xor dec with a non-zero step) > hold.
    // inc and dec together, or a zero step, both resolve to a hold.
    function automatic cnt_op_t decode_op(
        input logic clr,
        input logic ld,
        input logic inc,
        input logic dec,
        input logic step_nz
    );
        cnt_op_t op;
        op = OP_HOLD;
        if (clr) begin
            op = OP_CLR;
        end else if (ld) begin
            op = OP_LD;
        end else if (inc && !dec && step_nz) begin
            op = OP_INC;
        end else if (dec && !inc && step_nz) begin
            op = OP_DEC;
        end
        return op;
    endfunction

    // Remainder of val by modulus. The modulus is always an elaboration-time
    // constant at the call sites, so this folds to a constant divider.
    function automatic logic [MOD_W-1:0] mod_reduce(
        input logic [MOD_W-1:0] val,
        input logic [MOD_W-1:0] modulus
    );
        return val % modulus;
    endfunction

endpackage

// File: rtl/reg_cnt_updn_if.sv
// Command/status bundle of the reg_cnt_updn counter register.
// Optional compare port pair (cmp/match) is present only when the macro
// REG_CNT_UPDN_CMP_EN is defined.
interface reg_cnt_updn_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic [WIDTH-1:0]  din;
    logic              ld;
    logic              clr;
    logic              inc;
    logic              dec;
    logic [STEP_W-1:0] step;
    logic              sat;
    logic              flag_clr;
    logic [WIDTH-1:0]  dout;
    logic              zero;
    logic              tc;
    logic              ovf;
    logic              unf;
    logic              cmd_err;
`ifdef REG_CNT_UPDN_CMP_EN
    logic [WIDTH-1:0]  cmp;
    logic              match;

    modport master (
        output din, ld, clr, inc, dec, step, sat, flag_clr, cmp,
        input  dout, zero, tc, ovf, unf, cmd_err, match
    );

    modport slave (
        input  din, ld, clr, inc, dec, step, sat, flag_clr, cmp,
        output dout, zero, tc, ovf, unf, cmd_err, match
    );
`else
    modport master (
        output din, ld, clr, inc, dec, step, sat, flag_clr,
        input  dout, zero, tc, ovf, unf, cmd_err
    );

    modport slave (
        input  din, ld, clr, inc, dec, step, sat, flag_clr,
        output dout, zero, tc, ovf, unf, cmd_err
    );
`endif
endinterface

// File: rtl/reg_cnt_updn_step.sv
// cnt_step_addsub: combinational step arithmetic for reg_cnt_updn.
// Adds or subtracts a zero-extended step from the current count in
// WIDTH+1 bits, then wraps modulo MAXV+1 or saturates at 0/MAXV.
// crossed marks that a boundary was passed or hit on this update;
// over/under tell which direction. A zero step leaves everything idle.
module cnt_step_addsub
    import reg_cnt_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int MAXV   = 2**WIDTH-1
) (
    input  logic [WIDTH-1:0]  cur,
    input  logic [STEP_W-1:0] step,
    input  logic              up,
    input  logic              sat,
    output logic [WIDTH-1:0]  nxt,
    output logic              crossed,
    output logic              over,
    output logic              under
);

    localparam int AW = WIDTH + 1;
    localparam logic [AW-1:0] MAXV_X = AW'(MAXV);
    localparam logic [AW-1:0] MODV_X = AW'(MAXV + 1);

    logic [AW-1:0] cur_x;
    logic [AW-1:0] step_x;
    logic [AW-1:0] sum_x;
    logic [AW-1:0] wrap_dn_x;

    // Reduce an AW-bit value modulo MAXV+1 through the shared helper.
    function automatic logic [AW-1:0] mod_m(input logic [AW-1:0] v);
        return AW'(mod_reduce(MOD_W'(v), MOD_W'(MODV_X)));
    endfunction

    assign cur_x  = AW'(cur);
    assign step_x = AW'(step);
    assign sum_x  = cur_x + step_x;
    // cur < step here, so cur + modulus - (step mod modulus) stays positive
    // and below 2*modulus, which fits in AW bits.
    assign wrap_dn_x = cur_x + MODV_X - mod_m(step_x);

    // Select the next count and boundary indications for the requested direction.
    always_comb begin
        nxt     = cur;
        crossed = 1'b0;
        over    = 1'b0;
        under   = 1'b0;
        if (step_x != '0) begin
            if (up) begin
                if (sum_x <= MAXV_X) begin
                    nxt = WIDTH'(sum_x);
                end else begin
                    crossed = 1'b1;
                    over    = 1'b1;
                    nxt     = sat ? WIDTH'(MAXV_X) : WIDTH'(mod_m(sum_x));
                end
            end else begin
                if (cur_x >= step_x) begin
                    nxt = WIDTH'(cur_x - step_x);
                end else begin
                    crossed = 1'b1;
                    under   = 1'b1;
                    nxt     = sat ? '0 : WIDTH'(mod_m(wrap_dn_x));
                end
            end
        end
    end

endmodule

// File: rtl/reg_cnt_updn.sv
// reg_cnt_updn: modulo-N up/down counter register with programmable step,
// wrap/saturate mode, sticky overflow/underflow, terminal-count pulse and
// load-conflict pulse. All outputs except zero are registered.
// Optional feature: define REG_CNT_UPDN_CMP_EN to add the cmp input and the
// registered match output on the interface.
module reg_cnt_updn
    import reg_cnt_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int MAXV   = 2**WIDTH-1
) (
    input  logic          clk,
    input  logic          rst,
    reg_cnt_updn_if.slave bus
);

    localparam logic [WIDTH-1:0] MAXV_W = WIDTH'(MAXV);

    cnt_op_t          op;
    logic [WIDTH-1:0] as_nxt;
    logic             as_crossed;
    logic             as_over;
    logic             as_under;

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             cmd_err_q, cmd_err_d;
    logic             ovf_set;
    logic             unf_set;
`ifdef REG_CNT_UPDN_CMP_EN
    logic             match_q, match_d;
`endif

    assign op = decode_op(bus.clr, bus.ld, bus.inc, bus.dec, bus.step != '0);

    cnt_step_addsub #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W),
        .MAXV   (MAXV)
    ) u_step (
        .cur     (dout_q),
        .step    (bus.step),
        .up      (op == OP_INC),
        .sat     (bus.sat),
        .nxt     (as_nxt),
        .crossed (as_crossed),
        .over    (as_over),
        .under   (as_under)
    );

    // Next count, pulses and sticky-flag updates for the resolved command.
    always_comb begin
        dout_d    = dout_q;
        tc_d      = 1'b0;
        cmd_err_d = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case (op)
            OP_CLR: begin
                dout_d = '0;
            end
            OP_LD: begin
                // An out-of-range load clamps to MAXV and counts as overflow.
                if (bus.din > MAXV_W) begin
                    dout_d  = MAXV_W;
                    ovf_set = 1'b1;
                end else begin
                    dout_d = bus.din;
                end
                cmd_err_d = bus.inc | bus.dec;
            end
            OP_INC, OP_DEC: begin
                dout_d  = as_nxt;
                tc_d    = as_crossed;
                ovf_set = as_over;
                unf_set = as_under;
            end
            default: begin
            end
        endcase
        // A set event in the same cycle as flag_clr keeps the flag high.
        ovf_d = ovf_set | (ovf_q & ~bus.flag_clr);
        unf_d = unf_set | (unf_q & ~bus.flag_clr);
`ifdef REG_CNT_UPDN_CMP_EN
        match_d = (op != OP_HOLD) && (dout_d == bus.cmp);
`endif
    end

    // Count, flag and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q    <= '0;
            tc_q      <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            cmd_err_q <= 1'b0;
`ifdef REG_CNT_UPDN_CMP_EN
            match_q   <= 1'b0;
`endif
        end else begin
            dout_q    <= dout_d;
            tc_q      <= tc_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            cmd_err_q <= cmd_err_d;
`ifdef REG_CNT_UPDN_CMP_EN
            match_q   <= match_d;
`endif
        end
    end

    assign bus.dout    = dout_q;
    assign bus.zero    = (dout_q == '0);
    assign bus.tc      = tc_q;
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;
    assign bus.cmd_err = cmd_err_q;
`ifdef REG_CNT_UPDN_CMP_EN
    assign bus.match   = match_q;
`endif

endmodule

// File: tb/tb_reg_cnt_updn.sv
// Self-checking bench for reg_cnt_updn (WIDTH=8, STEP_W=4, MAXV=9).
// An integer model tracks the expected count and flags; a compare process
// checks every output on each falling edge, and directed steps also pin
// hand-computed values.
module tb_reg_cnt_updn;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;
    localparam int MAXV   = 9;

    typedef struct {
        int cnt;
        bit tc;
        bit ovf;
        bit unf;
        bit err;
        bit match;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    mdl_t mdl = '{cnt: 0, tc: 1'b0, ovf: 1'b0, unf: 1'b0, err: 1'b0, match: 1'b0};

    reg_cnt_updn_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

    reg_cnt_updn #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W),
        .MAXV   (MAXV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected state after one rising edge, from the counter's rules in plain integers.
    function automatic mdl_t model_next(input mdl_t cur);
        mdl_t n;
        int   s;
        int   v;
        bit   so;
        bit   su;
        bit   upd;
        n     = cur;
        n.tc  = 1'b0;
        n.err = 1'b0;
        so    = 1'b0;
        su    = 1'b0;
        upd   = 1'b0;
        s     = int'(bus.step);
        if (rst) begin
            n.cnt = 0;
            n.ovf = 1'b0;
            n.unf = 1'b0;
            n.match = 1'b0;
            return n;
        end
        if (bus.clr) begin
            n.cnt = 0;
            upd = 1'b1;
        end else if (bus.ld) begin
            upd = 1'b1;
            n.err = bus.inc || bus.dec;
            if (int'(bus.din) > MAXV) begin
                n.cnt = MAXV;
                so = 1'b1;
            end else begin
                n.cnt = int'(bus.din);
            end
        end else if ((bus.inc != bus.dec) && s != 0) begin
            upd = 1'b1;
            v = bus.inc ? cur.cnt + s : cur.cnt - s;
            if (v > MAXV) begin
                n.tc = 1'b1;
                so = 1'b1;
                n.cnt = bus.sat ? MAXV : v % (MAXV + 1);
            end else if (v < 0) begin
                n.tc = 1'b1;
                su = 1'b1;
                n.cnt = bus.sat ? 0 : ((v % (MAXV + 1)) + (MAXV + 1)) % (MAXV + 1);
            end else begin
                n.cnt = v;
            end
        end
        n.ovf = so || (cur.ovf && !bus.flag_clr);
        n.unf = su || (cur.unf && !bus.flag_clr);
`ifdef REG_CNT_UPDN_CMP_EN
        n.match = upd && (n.cnt == int'(bus.cmp));
`else
        n.match = 1'b0;
        if (upd) n.match = 1'b0;
`endif
        return n;
    endfunction

    always @(posedge clk) mdl <= model_next(mdl);

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dout",    int'(bus.dout),    mdl.cnt);
            check("zero",    int'(bus.zero),    int'(mdl.cnt == 0));
            check("tc",      int'(bus.tc),      int'(mdl.tc));
            check("ovf",     int'(bus.ovf),     int'(mdl.ovf));
            check("unf",     int'(bus.unf),     int'(mdl.unf));
            check("cmd_err", int'(bus.cmd_err), int'(mdl.err));
`ifdef REG_CNT_UPDN_CMP_EN
            check("match",   int'(bus.match),   int'(mdl.match));
`endif
        end
    end

    // Drive one cycle of inputs at a falling edge and wait for the next one.
    task automatic cyc(input logic ld_i, input int din_i, input logic clr_i,
                       input logic inc_i, input logic dec_i, input int step_i,
                       input logic sat_i, input logic fclr_i);
        bus.ld       = ld_i;
        bus.din      = WIDTH'(din_i);
        bus.clr      = clr_i;
        bus.inc      = inc_i;
        bus.dec      = dec_i;
        bus.step     = STEP_W'(step_i);
        bus.sat      = sat_i;
        bus.flag_clr = fclr_i;
        @(negedge clk);
    endtask

    initial begin
        bus.din = '0; bus.ld = 1'b0; bus.clr = 1'b0; bus.inc = 1'b0;
        bus.dec = 1'b0; bus.step = '0; bus.sat = 1'b0; bus.flag_clr = 1'b0;
`ifdef REG_CNT_UPDN_CMP_EN
        bus.cmp = '0;
`endif
        @(negedge clk);
        // Reset overrides a simultaneous load.
        rst = 1'b1;
        cyc(1, 5, 0, 0, 0, 0, 0, 0);
        check("rst_dout", int'(bus.dout), 0);
        check("rst_ovf",  int'(bus.ovf),  0);
        check("rst_tc",   int'(bus.tc),   0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Load, then clear beats load without a conflict pulse.
        cyc(1, 7, 0, 0, 0, 0, 0, 0);
        check("ld7", int'(bus.dout), 7);
        cyc(1, 5, 1, 0, 0, 0, 0, 0);
        check("clr_dout", int'(bus.dout), 0);
        check("clr_err",  int'(bus.cmd_err), 0);
        check("clr_zero", int'(bus.zero), 1);

        // Wrap up: 8 + 3 -> 1.
        cyc(1, 8, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 3, 0, 0);
        check("wrap_up_dout", int'(bus.dout), 1);
        check("wrap_up_tc",   int'(bus.tc),   1);
        check("wrap_up_ovf",  int'(bus.ovf),  1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("idle_tc",  int'(bus.tc),  0);
        check("idle_ovf", int'(bus.ovf), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        check("fclr_ovf", int'(bus.ovf), 0);

        // Saturating down: 2 - 5 -> 0, repeated.
        cyc(1, 2, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 5, 1, 0);
        check("sat_dn_dout", int'(bus.dout), 0);
        check("sat_dn_tc",   int'(bus.tc),   1);
        check("sat_dn_unf",  int'(bus.unf),  1);
        cyc(0, 0, 0, 0, 1, 5, 1, 0);
        check("sat_dn2_dout", int'(bus.dout), 0);
        check("sat_dn2_tc",   int'(bus.tc),   1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        check("fclr_unf", int'(bus.unf), 0);

        // Wrap down with large step: 3 - 15 -> 8; up 0 + 12 -> 2.
        cyc(1, 3, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 15, 0, 0);
        check("wrap_dn_dout", int'(bus.dout), 8);
        check("wrap_dn_unf",  int'(bus.unf),  1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 12, 0, 0);
        check("big_up_dout", int'(bus.dout), 2);
        check("big_up_ovf",  int'(bus.ovf),  1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // Conflicts and out-of-range load.
        cyc(1, 4, 0, 1, 0, 2, 0, 0);
        check("ldinc_dout", int'(bus.dout), 4);
        check("ldinc_err",  int'(bus.cmd_err), 1);
        cyc(0, 0, 0, 1, 1, 3, 0, 0);
        check("incdec_dout", int'(bus.dout), 4);
        check("incdec_tc",   int'(bus.tc),   0);
        check("incdec_err",  int'(bus.cmd_err), 0);
        cyc(1, 200, 0, 0, 0, 0, 0, 1);
        check("ld200_dout", int'(bus.dout), 9);
        check("ld200_ovf",  int'(bus.ovf),  1);

        // Saturated hold at MAXV, then zero step.
        cyc(0, 0, 0, 1, 0, 1, 1, 0);
        check("sathold_dout", int'(bus.dout), 9);
        check("sathold_tc",   int'(bus.tc),   1);
        cyc(0, 0, 0, 1, 0, 1, 1, 0);
        check("sathold2_tc", int'(bus.tc), 1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        check("step0_tc",   int'(bus.tc),   0);
        check("step0_dout", int'(bus.dout), 9);

        // Exact-reach down: 9 - 9 -> 0 with no boundary pulse.
        cyc(0, 0, 0, 0, 1, 9, 0, 1);
        check("exact_dn_dout", int'(bus.dout), 0);
        check("exact_dn_tc",   int'(bus.tc),   0);
        check("exact_dn_unf",  int'(bus.unf),  0);

        // Mid-run reset with flags set.
        cyc(0, 0, 0, 0, 1, 4, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 1, 0, 1, 0, 0);
        check("rst2_dout", int'(bus.dout), 0);
        check("rst2_unf",  int'(bus.unf),  0);
        rst = 1'b0;

`ifdef REG_CNT_UPDN_CMP_EN
        bus.cmp = 8'd6;
        cyc(1, 5, 0, 0, 0, 0, 0, 0);
        check("cmp_ld5_match", int'(bus.match), 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 0);
        check("cmp_inc_dout",  int'(bus.dout),  6);
        check("cmp_inc_match", int'(bus.match), 1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        check("cmp_hold_match", int'(bus.match), 0);
        bus.cmp = 8'd0;
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        check("cmp_clr_match", int'(bus.match), 1);
`endif

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_cnt_updn.md
Name: reg_cnt_updn

Overview:
- Parametrised successor to the team's load/clear/increment register.
- Modulo-N up/down counter register with:
  - programmable step
  - wrap or saturate mode
  - defined priority for every combination of simultaneous commands
  - sticky overflow/underflow flags and a terminal-count pulse
- Used as the general counter/pointer/timer register in datapaths and as a building block for FIFO pointers and timeouts.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- STEP_W, 4, width of the step input (1..WIDTH).
- MAXV, 2**WIDTH-1, highest legal count value; modulus is MAXV+1 (1 <= MAXV <= 2**WIDTH-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- din  in  WIDTH  load value.
- ld  in  1  load din.
- clr  in  1  synchronous clear of count.
- inc  in  1  count up by step.
- dec  in  1  count down by step.
- step  in  STEP_W  increment/decrement amount; 0 means hold.
- sat  in  1  1 = saturate at 0/MAXV, 0 = wrap modulo MAXV+1.
- flag_clr  in  1  clear sticky ovf/unf.
- dout  out  WIDTH  current count (registered).
- zero  out  1  combinational: dout == 0.
- tc  out  1  registered one-cycle pulse: boundary crossed/hit this update.
- ovf  out  1  sticky: up-count crossed MAXV, or load value > MAXV.
- unf  out  1  sticky: down-count crossed below 0.
- cmd_err  out  1  registered one-cycle pulse: conflicting command (ld with inc or dec).

Behaviour:
- Reset (rst=1 at posedge): dout=0, tc=0, ovf=0, unf=0, cmd_err=0. rst overrides all other inputs.
- Priority per cycle: rst > clr > ld > (inc xor dec) > hold.
  - clr: dout=0; flags untouched; no tc.
  - ld: dout=din if din<=MAXV, else dout=MAXV and ovf set.
    - If inc or dec is also asserted: the load still happens, the count is ignored, cmd_err pulses.
  - inc&&dec with no ld/clr: hold, no tc, no error.
- Arithmetic is done in WIDTH+1 bits; step is zero-extended. Let s = step.
- Up (inc only): t = dout + s.
  - t <= MAXV: dout = t.
  - Else if sat=1: dout=MAXV, tc=1, ovf set (only if dout<MAXV before or s>0).
  - Else (wrap): dout = t-(MAXV+1), tc=1, ovf set.
  - If s > MAXV, apply modulo reduction, not just a single subtract: t mod (MAXV+1).
- Down (dec only): if dout >= s, dout = dout-s. Otherwise:
  - sat=1: dout=0, tc=1, unf set.
  - sat=0: dout = dout + (MAXV+1) - (s mod (MAXV+1)), reduced mod MAXV+1; tc=1, unf set.
- s=0 with inc or dec: hold, no tc, no flags.
- Saturated hold (e.g. dout=MAXV, inc, sat=1): dout stays, tc=1 each cycle, ovf stays set.
- tc and cmd_err are high for exactly the cycle after the causing edge; otherwise 0.
- flag_clr clears ovf/unf at the edge. A set event in the same cycle wins (flag stays 1).
- Latency: all outputs except zero update one clock after the command; zero follows dout combinationally.

Optional Feature:
- Macro: REG_CNT_UPDN_CMP_EN.
- Defined: adds ports cmp (in, WIDTH) and match (out, 1, registered).
  - match=1 the cycle after any update where the new dout == cmp (including ld/clr).
  - Reset value of match is 0.
- Undefined: cmp/match ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package reg_cnt_pkg holds:
  - enum cnt_op_t {OP_HOLD, OP_CLR, OP_LD, OP_INC, OP_DEC}
  - priority-decode function
  - function computing modulo reduction by MAXV+1
- Sub-module cnt_step_addsub: combinational add/sub with wrap/saturate, producing next value, crossed flag and over/under indication.
- The top level holds registers, sticky flags and command decode.

Test Plan:
All scenarios use WIDTH=8, STEP_W=4, MAXV=9.
1. Reset/clr: rst high with ld=1, din=5 -> dout=0, flags 0. Then dout=7, clr=1 with ld=1 -> dout=0, no cmd_err.
2. Wrap up: dout=8, inc, step=3, sat=0 -> dout=1, tc pulse, ovf=1. Next cycle with no command -> tc=0, ovf stays 1.
3. Saturate: dout=2, dec, step=5, sat=1 -> dout=0, tc=1, unf=1. Repeat -> dout=0, tc=1. Then flag_clr with no set event -> unf=0.
4. Wrap down / large step: dout=3, dec, step=15, sat=0 -> dout=8 (3-15 mod 10). dout=0, inc, step=12 -> dout=2, ovf=1.
5. Conflicts: ld=1, inc=1, din=4 -> dout=4, cmd_err pulse. inc=dec=1 -> hold. ld din=200 -> dout=9, ovf=1.
6. With REG_CNT_UPDN_CMP_EN: cmp=6, dout=5, inc step=1 -> dout=6, match=1 next cycle. Then step=0 inc -> dout=6, match=0 (no update).
